// File: rtl/dca_join_if.sv
// dca_join_if.sv
//
// Handshake bundles used by dca_join.
//
//   dca_lane_if : NumLanes narrow DCA ports packed side by side.
//     master modport : per-lane initiators (drive q payload/q_valid, p_ready)
//     slave  modport : dca_join lane side (drives q_ready, p payload/p_valid)
//
//   dca_wide_if : one wide DCA port of DataWidth bits.
//     master modport : dca_join wide side (drives q payload/q_valid, p_ready)
//     slave  modport : wide SIMD responder (drives q_ready, p payload/p_valid)
//
// Op fields follow the standard DCA request layout: rnd_mode(3), op(4),
// op_mod(1), src_fmt(3), dst_fmt(3), int_fmt(2), vectorial_op(1), three
// operands. Responses carry result plus a 5-bit status.
`timescale 1ns/1ps

interface dca_lane_if #(
  parameter int unsigned LaneDataWidth = 64,
  parameter int unsigned NumLanes      = 8
);
  logic [NumLanes-1:0]                         q_valid;
  logic [NumLanes-1:0]                         q_ready;
  logic [NumLanes-1:0][2:0]                    rnd_mode;
  logic [NumLanes-1:0][3:0]                    op;
  logic [NumLanes-1:0]                         op_mod;
  logic [NumLanes-1:0][2:0]                    src_fmt;
  logic [NumLanes-1:0][2:0]                    dst_fmt;
  logic [NumLanes-1:0][1:0]                    int_fmt;
  logic [NumLanes-1:0]                         vectorial_op;
  logic [NumLanes-1:0][2:0][LaneDataWidth-1:0] operands;
  logic [NumLanes-1:0]                         p_valid;
  logic [NumLanes-1:0]                         p_ready;
  logic [NumLanes-1:0][LaneDataWidth-1:0]      result;
  logic [NumLanes-1:0][4:0]                    status;

  modport master (
    output q_valid, rnd_mode, op, op_mod, src_fmt, dst_fmt, int_fmt,
           vectorial_op, operands, p_ready,
    input  q_ready, p_valid, result, status
  );

  modport slave (
    input  q_valid, rnd_mode, op, op_mod, src_fmt, dst_fmt, int_fmt,
           vectorial_op, operands, p_ready,
    output q_ready, p_valid, result, status
  );
endinterface

interface dca_wide_if #(
  parameter int unsigned DataWidth = 512
);
  logic                      q_valid;
  logic                      q_ready;
  logic [2:0]                rnd_mode;
  logic [3:0]                op;
  logic                      op_mod;
  logic [2:0]                src_fmt;
  logic [2:0]                dst_fmt;
  logic [1:0]                int_fmt;
  logic                      vectorial_op;
  logic [2:0][DataWidth-1:0] operands;
  logic                      p_valid;
  logic                      p_ready;
  logic [DataWidth-1:0]      result;
  logic [4:0]                status;

  modport master (
    output q_valid, rnd_mode, op, op_mod, src_fmt, dst_fmt, int_fmt,
           vectorial_op, operands, p_ready,
    input  q_ready, p_valid, result, status
  );

  modport slave (
    input  q_valid, rnd_mode, op, op_mod, src_fmt, dst_fmt, int_fmt,
           vectorial_op, operands, p_ready,
    output q_ready, p_valid, result, status
  );
endinterface

// File: rtl/dca_join.sv
// dca_join.sv
//
// Joins NumLanes narrow DCA initiators into one wide SIMD DCA request and
// scatters the wide response back to the lanes.
//
// Each lane owns a one-entry request slot; the wide request issues when all
// slots are full, with op fields taken from lane 0 and lane i's operands
// placed in bits [LaneDataWidth*i +: LaneDataWidth]. The wide response is held
// until every lane has taken its slice; status is broadcast to all lanes.
//
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   slv     : dca_lane_if.slave, the NumLanes narrow ports
//   mst     : dca_wide_if.master, the wide port toward the responder
//   error_o : sticky op-field mismatch flag
//
// Optional feature: define DCA_JOIN_OPCHECK_EN to build the lane op-field
// comparator driving error_o. Without it error_o is tied to 0.
`timescale 1ns/1ps

module dca_join #(
  parameter int unsigned LaneDataWidth = 64,
  parameter int unsigned NumLanes      = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  dca_lane_if.slave  slv,
  dca_wide_if.master mst,
  output logic       error_o
);

  localparam int unsigned DataWidth   = LaneDataWidth * NumLanes;
  localparam int unsigned NumOperands = 3;

  typedef struct packed {
    logic [2:0] rnd_mode;
    logic [3:0] op;
    logic       op_mod;
    logic [2:0] src_fmt;
    logic [2:0] dst_fmt;
    logic [1:0] int_fmt;
    logic       vectorial_op;
  } ops_t;

  ops_t [NumLanes-1:0] lane_ops;

  always_comb begin
    lane_ops = '0;
    for (int i = 0; i < NumLanes; i++) begin
      lane_ops[i] = {slv.rnd_mode[i], slv.op[i], slv.op_mod[i], slv.src_fmt[i],
                     slv.dst_fmt[i], slv.int_fmt[i], slv.vectorial_op[i]};
    end
  end

  // Stage p0: per-lane request slots
  logic [NumLanes-1:0]                                   vld_p0;
  ops_t [NumLanes-1:0]                                   slot_ops_p0;
  logic [NumLanes-1:0][NumOperands-1:0][LaneDataWidth-1:0] slot_opnd_p0;

  logic                 q_fire;
  logic [NumLanes-1:0]  lane_q_ready;
  logic [NumLanes-1:0]  lane_q_fire;
  logic [NumOperands-1:0][DataWidth-1:0] wide_opnd;

  assign q_fire       = (&vld_p0) & mst.q_ready;
  // A full slot accepts a new request in the same cycle the wide request drains it.
  assign lane_q_ready = ~vld_p0 | {NumLanes{q_fire}};
  assign lane_q_fire  = slv.q_valid & lane_q_ready;
  assign slv.q_ready  = lane_q_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p0       <= '0;
      slot_ops_p0  <= '0;
      slot_opnd_p0 <= '0;
    end else begin
      for (int i = 0; i < NumLanes; i++) begin
        if (lane_q_fire[i]) begin
          vld_p0[i]       <= 1'b1;
          slot_ops_p0[i]  <= lane_ops[i];
          slot_opnd_p0[i] <= slv.operands[i];
        end else if (q_fire) begin
          vld_p0[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    wide_opnd = '0;
    for (int i = 0; i < NumLanes; i++) begin
      for (int k = 0; k < NumOperands; k++) begin
        wide_opnd[k][LaneDataWidth*i +: LaneDataWidth] = slot_opnd_p0[i][k];
      end
    end
  end

  // The payload comes straight from the slots, which cannot reload while the
  // wide request is stalled, so it is stable under back-pressure.
  assign mst.q_valid      = &vld_p0;
  assign mst.rnd_mode     = slot_ops_p0[0].rnd_mode;
  assign mst.op           = slot_ops_p0[0].op;
  assign mst.op_mod       = slot_ops_p0[0].op_mod;
  assign mst.src_fmt      = slot_ops_p0[0].src_fmt;
  assign mst.dst_fmt      = slot_ops_p0[0].dst_fmt;
  assign mst.int_fmt      = slot_ops_p0[0].int_fmt;
  assign mst.vectorial_op = slot_ops_p0[0].vectorial_op;
  assign mst.operands     = wide_opnd;

  // Stage p1: wide response register with per-lane consumption tracking
  logic                 vld_p1;
  logic [DataWidth-1:0] rsp_result_p1;
  logic [4:0]           rsp_status_p1;
  logic [NumLanes-1:0]  done_p1;

  logic [NumLanes-1:0]  lane_p_valid;
  logic [NumLanes-1:0]  lane_p_fire;
  logic                 all_done_now;
  logic                 wide_p_ready;
  logic                 p_fire;

  assign lane_p_valid = {NumLanes{vld_p1}} & ~done_p1;
  assign lane_p_fire  = lane_p_valid & slv.p_ready;
  // Counting this cycle's lane handshakes lets a new response land back to back.
  assign all_done_now = &(done_p1 | lane_p_fire);
  assign wide_p_ready = !vld_p1 || all_done_now;
  assign p_fire       = mst.p_valid & wide_p_ready;

  assign mst.p_ready  = wide_p_ready;
  assign slv.p_valid  = lane_p_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1        <= 1'b0;
      rsp_result_p1 <= '0;
      rsp_status_p1 <= '0;
      done_p1       <= '0;
    end else if (p_fire) begin
      vld_p1        <= 1'b1;
      rsp_result_p1 <= mst.result;
      rsp_status_p1 <= mst.status;
      done_p1       <= '0;
    end else if (vld_p1 && all_done_now) begin
      vld_p1  <= 1'b0;
      done_p1 <= '0;
    end else begin
      done_p1 <= done_p1 | lane_p_fire;
    end
  end

  always_comb begin
    slv.result = '0;
    slv.status = '0;
    for (int i = 0; i < NumLanes; i++) begin
      slv.result[i] = rsp_result_p1[LaneDataWidth*i +: LaneDataWidth];
      slv.status[i] = rsp_status_p1;
    end
  end

`ifdef DCA_JOIN_OPCHECK_EN
  function automatic logic ops_mismatch(input ops_t [NumLanes-1:0] ops);
    logic diff;
    diff = 1'b0;
    for (int i = 1; i < NumLanes; i++) begin
      if (ops[i] != ops[0]) diff = 1'b1;
    end
    return diff;
  endfunction

  logic error_q;

  // Sticky until reset; the mismatching request still issues.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      error_q <= 1'b0;
    end else if ((&vld_p0) && ops_mismatch(slot_ops_p0)) begin
      error_q <= 1'b1;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_dca_join.sv
`timescale 1ns/1ps

module tb_dca_join;

  localparam int NL  = 4;
  localparam int LW  = 64;
  localparam int WW  = LW * NL;

  typedef struct packed {
    logic [2:0] rnd_mode;
    logic [3:0] op;
    logic       op_mod;
    logic [2:0] src_fmt;
    logic [2:0] dst_fmt;
    logic [1:0] int_fmt;
    logic       vectorial_op;
  } ops_t;

  typedef struct packed {
    ops_t             ops;
    logic [2:0][63:0] opnd;
  } lreq_t;

  typedef struct packed {
    logic [WW-1:0] result;
    logic [4:0]    status;
  } wrsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;

  always #5 clk = ~clk;

  dca_lane_if #(.LaneDataWidth(LW), .NumLanes(NL)) lane_if ();
  dca_wide_if #(.DataWidth(WW)) wide_if ();

  dca_join #(.LaneDataWidth(LW), .NumLanes(NL)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .slv     (lane_if.slave),
    .mst     (wide_if.master),
    .error_o (err)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus drive state
  int            mode = 0;  // 0 directed, 1 streaming, 2 random
  logic [NL-1:0] drv_qv = '0;
  lreq_t         drv_req [NL];
  logic [NL-1:0] drv_pr = '0;
  logic          drv_mqr = 1'b0;
  logic          drv_pv = 1'b0;
  logic [WW-1:0] drv_res = '0;
  logic [4:0]    drv_st = '0;
  ops_t          cur_ops = '0;

  // Reference model: requests accepted per lane awaiting issue, every wide
  // response accepted so far, and how many of them each lane has consumed.
  lreq_t pend [NL][$];
  wrsp_t hist [$];
  int    rd_idx [NL];
  logic  err_exp = 1'b0;

  // Handshakes seen in the most recent cycle
  logic [NL-1:0] lqf = '0;
  logic [NL-1:0] lpf = '0;
  logic          wqf = 1'b0;
  logic          wpf = 1'b0;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ops_t rand_ops();
    logic [31:0] r;
    r = $urandom;
    return r[16:0];
  endfunction

  function automatic lreq_t rand_req();
    lreq_t q;
    q.ops = cur_ops;
    for (int k = 0; k < 3; k++) q.opnd[k] = {$urandom, $urandom};
    return q;
  endfunction

  function automatic logic [WW-1:0] rand_wide();
    logic [WW-1:0] r;
    for (int j = 0; j < WW/32; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  task automatic apply();
    for (int i = 0; i < NL; i++) begin
      lane_if.q_valid[i]      = drv_qv[i];
      lane_if.rnd_mode[i]     = drv_req[i].ops.rnd_mode;
      lane_if.op[i]           = drv_req[i].ops.op;
      lane_if.op_mod[i]       = drv_req[i].ops.op_mod;
      lane_if.src_fmt[i]      = drv_req[i].ops.src_fmt;
      lane_if.dst_fmt[i]      = drv_req[i].ops.dst_fmt;
      lane_if.int_fmt[i]      = drv_req[i].ops.int_fmt;
      lane_if.vectorial_op[i] = drv_req[i].ops.vectorial_op;
      lane_if.operands[i]     = drv_req[i].opnd;
    end
    lane_if.p_ready = drv_pr;
    wide_if.q_ready = drv_mqr;
    wide_if.p_valid = drv_pv;
    wide_if.result  = drv_res;
    wide_if.status  = drv_st;
  endtask

  task automatic settle();
    apply();
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_lane_q_ready"}, lane_if.q_ready, {NL{1'b1}});
    chk({tag, "_lane_p_valid"}, lane_if.p_valid, '0);
    chk({tag, "_mst_q_valid"}, wide_if.q_valid, 1'b0);
    chk({tag, "_mst_p_ready"}, wide_if.p_ready, 1'b1);
    chk({tag, "_error"}, err, 1'b0);
    chk({tag, "_mst_opnd0"}, wide_if.operands[0], '0);
    chk({tag, "_lane_result"}, lane_if.result, '0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NL; i++) begin
      pend[i].delete();
      rd_idx[i] = 0;
    end
    hist.delete();
    err_exp = 1'b0;
  endtask

  task automatic auto_update();
    logic [31:0] r;
    for (int i = 0; i < NL; i++) begin
      if (mode == 0) begin
        if (lqf[i]) drv_qv[i] = 1'b0;
      end else if (lqf[i] || !drv_qv[i]) begin
        drv_qv[i]  = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
        drv_req[i] = rand_req();
      end
    end
    if (mode != 0) begin
      r = $urandom;
      drv_pr  = (mode == 1) ? {NL{1'b1}} : r[NL-1:0];
      drv_mqr = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    if (mode == 0) begin
      if (wpf) drv_pv = 1'b0;
    end else if (wpf || !drv_pv) begin
      r = $urandom;
      drv_pv  = (mode == 1) ? 1'b1 : ($urandom_range(0, 1) != 0);
      drv_res = rand_wide();
      drv_st  = r[4:0];
    end
  endtask

  // One clock cycle: check DUT against the model at the falling edge, update
  // the model with the handshakes of this cycle, then advance stimulus.
  task automatic tick();
    logic          all_pend;
    logic          exp_pr;
    logic [NL-1:0] exp_qr;
    logic [NL-1:0] exp_pv;
    logic [WW-1:0] e;
    ops_t          obs_ops;
    apply();
    @(negedge clk);
    lqf = '0; lpf = '0; wqf = 1'b0; wpf = 1'b0;
    if (!rst_n) begin
      reset_checks("rst");
    end else begin
      all_pend = 1'b1;
      for (int i = 0; i < NL; i++) if (pend[i].size() == 0) all_pend = 1'b0;
      chk("mst_q_valid", wide_if.q_valid, all_pend);
      for (int i = 0; i < NL; i++) exp_qr[i] = (pend[i].size() == 0) || (all_pend && drv_mqr);
      chk("lane_q_ready", lane_if.q_ready, exp_qr);
      for (int i = 0; i < NL; i++) exp_pv[i] = (rd_idx[i] < hist.size());
      chk("lane_p_valid", lane_if.p_valid, exp_pv);
      lqf = lane_if.q_valid & lane_if.q_ready;
      lpf = lane_if.p_valid & lane_if.p_ready;
      wqf = wide_if.q_valid & wide_if.q_ready;
      exp_pr = 1'b1;
      for (int i = 0; i < NL; i++) if (rd_idx[i] + int'(lpf[i]) < hist.size()) exp_pr = 1'b0;
      chk("mst_p_ready", wide_if.p_ready, exp_pr);
      wpf = wide_if.p_valid & wide_if.p_ready;
      chk("error_o", err, err_exp);
      for (int i = 0; i < NL; i++) begin
        if (lpf[i] && rd_idx[i] < hist.size()) begin
          chk($sformatf("lane%0d_result", i), lane_if.result[i], hist[rd_idx[i]].result[LW*i +: LW]);
          chk($sformatf("lane%0d_status", i), lane_if.status[i], hist[rd_idx[i]].status);
          rd_idx[i]++;
        end
      end
`ifdef DCA_JOIN_OPCHECK_EN
      if (all_pend) begin
        for (int i = 1; i < NL; i++) if (pend[i][0].ops != pend[0][0].ops) err_exp = 1'b1;
      end
`endif
      if (wqf && all_pend) begin
        obs_ops = {wide_if.rnd_mode, wide_if.op, wide_if.op_mod, wide_if.src_fmt,
                   wide_if.dst_fmt, wide_if.int_fmt, wide_if.vectorial_op};
        chk("wide_ops", obs_ops, pend[0][0].ops);
        for (int k = 0; k < 3; k++) begin
          for (int i = 0; i < NL; i++) e[LW*i +: LW] = pend[i][0].opnd[k];
          chk($sformatf("wide_opnd%0d", k), wide_if.operands[k], e);
        end
        for (int i = 0; i < NL; i++) void'(pend[i].pop_front());
      end
      for (int i = 0; i < NL; i++) if (lqf[i]) pend[i].push_back(drv_req[i]);
      if (wpf) hist.push_back({drv_res, drv_st});
    end
    @(posedge clk);
    #1;
    auto_update();
  endtask

  initial begin
    lreq_t         stag [NL];
    ops_t          f;
    logic [WW-1:0] e;
    logic [WW-1:0] exp0;
    logic [63:0]   a_v, b_v, c_v, d_v;

    for (int i = 0; i < NL; i++) begin
      drv_req[i] = '0;
      rd_idx[i]  = 0;
    end

    // Reset held low
    rst_n = 1'b0;
    settle();
    reset_checks("por");
    tick();
    tick();
    rst_n = 1'b1;

    // Staggered issue: lane i loads on cycle i, wide valid on cycle NL
    drv_mqr = 1'b0;
    f = rand_ops();
    cur_ops = f;
    for (int i = 0; i < NL; i++) begin
      stag[i] = rand_req();
      stag[i].opnd[0] = 64'h1111_1111_1111_1111 * (i + 1);
      drv_req[i] = stag[i];
      drv_qv[i]  = 1'b1;
      settle();
      chk($sformatf("stag_qv_c%0d", i), wide_if.q_valid, 1'b0);
      tick();
    end
    settle();
    chk("stag_qv_rise", wide_if.q_valid, 1'b1);
    exp0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    chk("stag_opnd0", wide_if.operands[0], exp0);
    chk("stag_op", wide_if.op, f.op);
    chk("stag_rnd", wide_if.rnd_mode, f.rnd_mode);

    // Back-pressure for 5 cycles with new lane requests waiting
    for (int i = 0; i < NL; i++) begin
      drv_req[i] = rand_req();
      drv_qv[i]  = 1'b1;
    end
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("bp_lane_q_ready", lane_if.q_ready, '0);
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < NL; i++) e[LW*i +: LW] = stag[i].opnd[k];
        chk($sformatf("bp_stable_opnd%0d", k), wide_if.operands[k], e);
      end
      tick();
    end
    drv_mqr = 1'b1;
    settle();
    chk("bp_release_q_ready", lane_if.q_ready, {NL{1'b1}});
    tick();
    settle();
    chk("bp_reload_qv", wide_if.q_valid, 1'b1);
    tick();

    // Out-of-order consume of one held wide response
    drv_pr = '0;
    a_v = {$urandom, $urandom};
    b_v = {$urandom, $urandom};
    c_v = {$urandom, $urandom};
    d_v = {$urandom, $urandom};
    drv_res = {a_v, b_v, c_v, d_v};
    drv_st  = 5'b00001;
    drv_pv  = 1'b1;
    settle();
    chk("ooo_accept", wide_if.p_ready, 1'b1);
    tick();
    drv_pr[2] = 1'b1;
    settle();
    chk("ooo_p1_valid", lane_if.p_valid, 4'b1111);
    chk("ooo_lane2", lane_if.result[2], b_v);
    chk("ooo_lane2_st", lane_if.status[2], 5'b00001);
    chk("ooo_p1_ready", wide_if.p_ready, 1'b0);
    tick();
    drv_pr[2] = 1'b0;
    settle();
    chk("ooo_p2_valid", lane_if.p_valid, 4'b1011);
    chk("ooo_p2_ready", wide_if.p_ready, 1'b0);
    tick();
    drv_pr[0] = 1'b1;
    settle();
    chk("ooo_lane0", lane_if.result[0], d_v);
    chk("ooo_p3_ready", wide_if.p_ready, 1'b0);
    tick();
    drv_pr[0] = 1'b0;
    settle();
    chk("ooo_p4_valid", lane_if.p_valid, 4'b1010);
    chk("ooo_p4_ready", wide_if.p_ready, 1'b0);
    tick();
    drv_pr[1] = 1'b1;
    drv_pr[3] = 1'b1;
    settle();
    chk("ooo_p5_ready", wide_if.p_ready, 1'b1);
    chk("ooo_lane1", lane_if.result[1], c_v);
    chk("ooo_lane3", lane_if.result[3], a_v);
    chk("ooo_lane3_st", lane_if.status[3], 5'b00001);
    tick();
    drv_pr = '0;
    settle();
    chk("ooo_drained", lane_if.p_valid, '0);

    // Streaming: every valid and ready held high
    cur_ops = rand_ops();
    mode = 1;
    auto_update();
    tick();
    tick();
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("stream_q_fire", wqf, 1'b1);
      chk("stream_p_fire", wpf, 1'b1);
    end

    // Random traffic on every handshake
    mode = 2;
    for (int c = 0; c < 300; c++) tick();

    // Reset mid-operation drops everything immediately
    mode    = 0;
    rst_n   = 1'b0;
    drv_qv  = '0;
    drv_pr  = '0;
    drv_mqr = 1'b0;
    drv_pv  = 1'b0;
    settle();
    reset_checks("midrst");
    clear_model();
    tick();
    tick();
    rst_n = 1'b1;

    // Op-field mismatch: lane 1 sends MUL, others ADD
    f = rand_ops();
    f.op = 4'd2;
    cur_ops = f;
    for (int i = 0; i < NL; i++) begin
      drv_req[i] = rand_req();
      drv_qv[i]  = 1'b1;
    end
    drv_req[1].ops.op = 4'd3;
    drv_mqr = 1'b1;
    tick();
    settle();
    chk("opchk_err_pre", err, 1'b0);
    chk("opchk_issue_qv", wide_if.q_valid, 1'b1);
    chk("opchk_issue_op", wide_if.op, 4'd2);
    tick();
    for (int c = 0; c < 4; c++) begin
      settle();
`ifdef DCA_JOIN_OPCHECK_EN
      chk($sformatf("opchk_err_c%0d", c), err, 1'b1);
`else
      chk($sformatf("opchk_err_c%0d", c), err, 1'b0);
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
